// File: rtl/key_matrix_scan_if.sv
// key_matrix_scan_if: key event bus (key_code, key_valid strobe, key_down level); master drives, slave observes
interface key_matrix_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  modport master (output key_code, key_valid, key_down);
  modport slave  (input  key_code, key_valid, key_down);
endinterface

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 active-low key matrix scanner with frame debounce; ports cp, rst_n (async active-low), KEY_ROW row drive, KEY_COL column sense, key (master: key_code, key_valid, key_down); macro KEY_REPEAT_EN enables auto-repeat strobes
module key_matrix_scan #(
  parameter int SCAN_DIV      = 2500,
  parameter int DEB_CNT       = 3,
  parameter int REPEAT_FRAMES = 50
) (
  input  logic        cp,
  input  logic        rst_n,
  output logic [3:0]  KEY_ROW,
  input  logic [3:0]  KEY_COL,
  key_matrix_scan_if.master key
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam bit ONE = DEB_CNT == 1;
  if (SCAN_DIV < 3 || DEB_CNT < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("key_matrix_scan: SCAN_DIV must be >= 3, DEB_CNT and REPEAT_FRAMES >= 1");
  end
  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;
  state_t        state;
  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] div;
  logic [1:0]    row;
  logic [15:0]   snap;
  logic          frame_done;
  logic [CW-1:0] cnt;
  logic [3:0]    cand, code;
  logic          tick, none, single, cnt_hit;
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rpt;
`endif
  assign tick    = div == DW'(SCAN_DIV - 1);
  // snap holds pressed keys active-high, bit index = row*4 + col
  assign none    = snap == '0;
  assign single  = !none && (snap & (snap - 16'd1)) == '0;
  assign cnt_hit = cnt + 1'b1 == CW'(DEB_CNT);
  always_comb begin
    code = '0;
    for (int i = 0; i < 16; i++) if (snap[i]) code = 4'(i);
  end
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      col_s1     <= 4'hF;
      col_s2     <= 4'hF;
      div        <= '0;
      row        <= '0;
      KEY_ROW    <= 4'b1110;
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      col_s1     <= KEY_COL;
      col_s2     <= col_s1;
      div        <= tick ? '0 : div + 1'b1;
      frame_done <= tick && row == 2'd3;
      if (tick) begin
        snap[{row, 2'b00} +: 4] <= ~col_s2;
        row     <= row + 2'd1;
        KEY_ROW <= {KEY_ROW[2:0], KEY_ROW[3]};
      end
    end
  end
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cand          <= '0;
      key.key_code  <= '0;
      key.key_valid <= 1'b0;
      key.key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt           <= '0;
`endif
    end else begin
      key.key_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          IDLE:
            if (single && ONE) begin
              state         <= PRESSED;
              key.key_code  <= code;
              key.key_valid <= 1'b1;
              key.key_down  <= 1'b1;
            end else if (single) begin
              state <= DEB_PRESS;
              cand  <= code;
              cnt   <= CW'(1);
            end
          DEB_PRESS:
            if (!single) state <= IDLE;
            else if (code != cand) begin
              cand <= code;
              cnt  <= CW'(1);
            end else if (cnt_hit) begin
              state         <= PRESSED;
              key.key_code  <= cand;
              key.key_valid <= 1'b1;
              key.key_down  <= 1'b1;
            end else cnt <= cnt + 1'b1;
          PRESSED:
            if (none && ONE) begin
              state        <= IDLE;
              key.key_down <= 1'b0;
`ifdef KEY_REPEAT_EN
              rpt          <= '0;
`endif
            end else if (none) begin
              state <= DEB_RELEASE;
              cnt   <= CW'(1);
`ifdef KEY_REPEAT_EN
              rpt   <= '0;
`endif
            end
`ifdef KEY_REPEAT_EN
            // MULTI and any SINGLE both count as held frames for repeat
            else if (rpt + 1'b1 == RW'(REPEAT_FRAMES)) begin
              rpt           <= '0;
              key.key_valid <= 1'b1;
            end else rpt <= rpt + 1'b1;
`endif
          DEB_RELEASE: begin
`ifdef KEY_REPEAT_EN
            rpt <= '0;
`endif
            if (!none) state <= PRESSED;
            else if (cnt_hit) begin
              state        <= IDLE;
              key.key_down <= 1'b0;
            end else cnt <= cnt + 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: table-driven and randomized frame-level checks of key_matrix_scan against a run-length reference model
module tb_key_matrix_scan;
  localparam int SD = 4;
  localparam int DEB = 3;
`ifdef KEY_REPEAT_EN
  localparam int RF = 2;
`else
  localparam int RF = 50;
`endif
  localparam int FRAME = 4 * SD;
  typedef struct {
    logic [15:0] keys;
    int frames;
    int s;
    int sr;
    int code;
    int down;
  } vec_t;
  logic cp = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_row, key_col;
  logic [15:0] keys = '0;
  key_matrix_scan_if kif();
  key_matrix_scan #(.SCAN_DIV(SD), .DEB_CNT(DEB), .REPEAT_FRAMES(RF)) dut (
    .cp(cp), .rst_n(rst_n), .KEY_ROW(key_row), .KEY_COL(key_col), .key(kif)
  );
  always #5 cp = ~cp;
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++) if (!key_row[r]) key_col = key_col & ~keys[r*4 +: 4];
  end
  int checks = 0, errors = 0, cyc = 0, nval = 0;
  logic [15:0] fq[$];
  int run_len, run_code, empty, rep, m_code, m_down, exp_v;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask
  function automatic void model_reset();
    run_len = 0; run_code = 0; empty = 0; rep = 0; m_code = 0; m_down = 0; exp_v = 0;
  endfunction
  // One classified frame: a press needs DEB consecutive frames of the same lone key,
  // a release needs DEB consecutive empty frames.
  function automatic void model_step(input logic [15:0] m);
    int c;
    bit one;
    one = $countones(m) == 1;
    c = one ? $clog2(m) : -1;
    exp_v = 0;
    if (m_down == 0) begin
      if (one && run_len > 0 && c == run_code) run_len++;
      else if (one) begin run_len = 1; run_code = c; end
      else run_len = 0;
      if (run_len == DEB) begin
        m_down = 1; m_code = c; exp_v = 1; run_len = 0; empty = 0; rep = 0;
      end
    end else if (m == 0) begin
      empty++; rep = 0;
      if (empty == DEB) begin m_down = 0; empty = 0; end
    end else if (empty > 0) begin
      empty = 0; rep = 0;
    end else begin
`ifdef KEY_REPEAT_EN
      rep++;
      if (rep == RF) begin rep = 0; exp_v = 1; end
`endif
    end
  endfunction
  always @(posedge cp or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
  always @(negedge cp) if (rst_n) begin
    logic [3:0] er;
    er = ~(4'b0001 << ((cyc / SD) % 4));
    chk("key_row", int'(key_row), int'(er));
    if (kif.key_valid) nval++;
    if (cyc > FRAME && cyc % FRAME == 1 && fq.size() > 0) begin
      model_step(fq.pop_front());
      chk("key_valid", int'(kif.key_valid), exp_v);
      chk("key_down", int'(kif.key_down), m_down);
      if (exp_v != 0) chk("key_code", int'(kif.key_code), m_code);
    end else chk("stray_valid", int'(kif.key_valid), 0);
  end
  // Keys change just after a frame's classification, so each frame sees one mask.
  task automatic apply(input logic [15:0] m, input int n);
    for (int f = 0; f < n; f++) begin
      keys = m;
      fq.push_back(m);
      repeat (FRAME) @(negedge cp);
      #1;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    model_reset();
    repeat (2) @(posedge cp);
    @(negedge cp);
    rst_n = 1'b1;
    @(negedge cp);
    #1;
  endtask
  vec_t tab[22];
  initial begin
    int base, exp_s;
    logic [15:0] m;
    tab[0]  = '{16'h0000, 4, 0, 0, 0, 0};
    tab[1]  = '{16'h0200, 4, 1, 1, 9, 1};
    tab[2]  = '{16'h0000, 2, 0, 0, 9, 1};
    tab[3]  = '{16'h0000, 1, 0, 0, 9, 0};
    tab[4]  = '{16'h0008, 1, 0, 0, 9, 0};
    tab[5]  = '{16'h0000, 1, 0, 0, 9, 0};
    tab[6]  = '{16'h0020, 3, 1, 1, 5, 1};
    tab[7]  = '{16'h0420, 2, 0, 1, 5, 1};
    tab[8]  = '{16'h0400, 3, 0, 1, 5, 1};
    tab[9]  = '{16'h0000, 3, 0, 0, 5, 0};
    tab[10] = '{16'h8000, 3, 1, 1, 15, 1};
    tab[11] = '{16'h0000, 1, 0, 0, 15, 1};
    tab[12] = '{16'h8000, 1, 0, 0, 15, 1};
    tab[13] = '{16'h8000, 10, 0, 5, 15, 1};
    tab[14] = '{16'h0000, 3, 0, 0, 15, 0};
    tab[15] = '{16'h0003, 4, 0, 0, 15, 0};
    tab[16] = '{16'h0000, 1, 0, 0, 15, 0};
    tab[17] = '{16'h0040, 2, 0, 0, 15, 0};
    tab[18] = '{16'h0080, 3, 1, 1, 7, 1};
    tab[19] = '{16'h0000, 3, 0, 0, 7, 0};
    tab[20] = '{16'h0001, 3, 1, 1, 0, 1};
    tab[21] = '{16'h0000, 3, 0, 0, 0, 0};
    keys = '0;
    do_reset();
    chk("reset_code", int'(kif.key_code), 0);
    chk("reset_down", int'(kif.key_down), 0);
    for (int i = 0; i < 22; i++) begin
      base = nval;
`ifdef KEY_REPEAT_EN
      exp_s = tab[i].sr;
`else
      exp_s = tab[i].s;
`endif
      apply(tab[i].keys, tab[i].frames);
      chk($sformatf("tab%0d_strobes", i), nval - base, exp_s);
      chk($sformatf("tab%0d_code", i), int'(kif.key_code), tab[i].code);
      chk($sformatf("tab%0d_down", i), int'(kif.key_down), tab[i].down);
    end
    apply(16'h1000, 3);
    apply(16'h0000, 3);
    apply(16'h0001, 2);
    #22;
    rst_n = 1'b0;
    #1;
    chk("async_row", int'(key_row), 4'b1110);
    chk("async_code", int'(kif.key_code), 0);
    chk("async_valid", int'(kif.key_valid), 0);
    chk("async_down", int'(kif.key_down), 0);
    do_reset();
    base = nval;
    apply(16'h0001, 4);
    chk("post_reset_strobes", nval - base, 1);
    chk("post_reset_code", int'(kif.key_code), 0);
    chk("post_reset_down", int'(kif.key_down), 1);
    apply(16'h0000, 3);
    for (int i = 0; i < 40; i++) begin
      int k, a;
      k = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      m = 16'h0001 << a;
      if (k == 0) m = '0;
      else if (k == 3) m = m | (16'h0001 << ((a + 1 + $urandom_range(0, 14)) % 16));
      apply(m, $urandom_range(1, 5));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
